// File: rtl/nco_tuning_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : nco_tuning_controller_if
//  Description : Request/result bundle between the keypad/host side and the
//                NCO tuning controller. The master side issues conversion
//                requests and supplies the accumulator wrap pulse; the slave
//                side (controller) returns status and committed outputs.
//  Signals     : start, digit[3:0] (BCD, [3]=thousands), range_khz, wave_sel,
//                phase_wrap, wrap_sync  -> slave
//                busy, done, err, tw_out, wave_out -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface nco_tuning_controller_if #(
    parameter int PHASE_W = 32
);
    logic                 start;
    logic [3:0][3:0]      digit;
    logic                 range_khz;
    logic [3:0]           wave_sel;
    logic                 phase_wrap;
    logic                 wrap_sync;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [PHASE_W-1:0]   tw_out;
    logic [3:0]           wave_out;

    modport master (
        output start, digit, range_khz, wave_sel, phase_wrap, wrap_sync,
        input  busy, done, err, tw_out, wave_out
    );

    modport slave (
        input  start, digit, range_khz, wave_sel, phase_wrap, wrap_sync,
        output busy, done, err, tw_out, wave_out
    );
endinterface
`default_nettype wire

// File: rtl/nco_tuning_controller.sv
`default_nettype none
// ============================================================================
//  Module      : nco_tuning_controller
//  Description : Converts four BCD digits (Hz or kHz) into a binary frequency,
//                multiplies it by TW_SCALE with a serial LSB-first shift-add
//                multiplier and commits the resulting tuning word together with
//                the waveform code, either immediately or on an accumulator
//                wrap, so the NCO never sees a half-updated setting.
//  Ports       : clk_50MHz - system clock
//                rst       - asynchronous active-high reset
//                bus       - nco_tuning_controller_if.slave (request/result)
//  Revision    : 1.0  initial release
// ============================================================================
module nco_tuning_controller #(
    parameter int                   PHASE_W    = 32,
    parameter int                   FREQ_W     = 24,
    parameter int                   FRAC_W     = 16,
    parameter int unsigned          TW_SCALE   = 5629500,
    parameter logic [PHASE_W-1:0]   DEFAULT_TW = 32'd85899
) (
    input  wire logic               clk_50MHz,
    input  wire logic               rst,
    nco_tuning_controller_if.slave  bus
);

    localparam int c_PROD_W = FREQ_W + 24;
    localparam int c_CNT_W  = $clog2(FREQ_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BCD    = 3'd1,
        S_SCALE  = 3'd2,
        S_MUL    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [c_CNT_W-1:0]     r_cnt;
    logic [3:0][3:0]        r_digit;
    logic                   r_khz;
    logic [3:0]             r_wave;
    logic [FREQ_W-1:0]      r_freq;
    logic [c_PROD_W-1:0]    r_prod;
    logic [c_PROD_W-1:0]    r_mcand;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [PHASE_W-1:0]     r_tw;
    logic [3:0]             r_wave_out;

    logic [3:0]             w_cur_digit;
    logic                   w_bad_digit;
    logic                   w_cnt_zero;
    logic                   w_commit_ok;

    // During BCD r_cnt walks 3..0, so its low bits select the current digit
    // (thousands first).
    assign w_cur_digit = r_digit[r_cnt[1:0]];
    assign w_bad_digit = (w_cur_digit > 4'd9);
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_commit_ok = !bus.wrap_sync || bus.phase_wrap;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_BCD;
            S_BCD: begin
                if (w_bad_digit)     w_next = S_IDLE;
                else if (w_cnt_zero) w_next = S_SCALE;
            end
            S_SCALE:  w_next = S_MUL;
            S_MUL:    if (w_cnt_zero) w_next = S_COMMIT;
            S_COMMIT: if (w_commit_ok) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_digit    <= '0;
            r_khz      <= 1'b0;
            r_wave     <= 4'd0;
            r_freq     <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_tw       <= DEFAULT_TW;
            r_wave_out <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_digit <= bus.digit;
                        r_khz   <= bus.range_khz;
                        r_wave  <= bus.wave_sel;
                        r_freq  <= '0;
                        r_cnt   <= c_CNT_W'(3);
                        r_busy  <= 1'b1;
                    end
                end
                S_BCD: begin
                    if (w_bad_digit) begin
                        r_err  <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        // freq*10 + digit, with x10 as x8 + x2
                        r_freq <= (r_freq << 3) + (r_freq << 1)
                                + {{(FREQ_W-4){1'b0}}, w_cur_digit};
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                S_SCALE: begin
                    // x1000 as x1024 - x16 - x8
                    if (r_khz) begin
                        r_freq <= (r_freq << 10) - (r_freq << 4) - (r_freq << 3);
                    end
                    r_prod  <= '0;
                    r_mcand <= c_PROD_W'(TW_SCALE);
                    r_cnt   <= c_CNT_W'(FREQ_W - 1);
                end
                S_MUL: begin
                    // Multiplier bits are consumed from r_freq[0] while the
                    // multiplicand shifts up, i.e. TW_SCALE << i for bit i.
                    if (r_freq[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_freq  <= r_freq >> 1;
                    r_mcand <= r_mcand << 1;
                    r_cnt   <= r_cnt - 1'b1;
                end
                S_COMMIT: begin
                    if (w_commit_ok) begin
                        r_tw       <= PHASE_W'(r_prod >> FRAC_W);
                        r_wave_out <= r_wave;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.tw_out   = r_tw;
    assign bus.wave_out = r_wave_out;

endmodule
`default_nettype wire
